// File: rtl/xm23_exec_ctrl.sv
// XM23 execution controller: step/run/halt/sleep gating with breakpoint slots.
// Optional cycle counter enabled by defining XM23_EXEC_CYCLE_CNT_EN.
module xm23_exec_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int NUM_BKPT = 4,
    parameter int CNT_W    = 32,
    localparam int IDX_W   = (NUM_BKPT > 1) ? $clog2(NUM_BKPT) : 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              step_req,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              bkpt_wr_en,
    input  logic [IDX_W-1:0]  bkpt_wr_idx,
    input  logic [ADDR_W-1:0] bkpt_wr_addr,
    input  logic              bkpt_wr_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instr_done,
    input  logic              slp,
    output logic              cpu_run,
    output logic              halted,
    output logic              bkpt_hit,
    output logic [IDX_W-1:0]  bkpt_hit_idx,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        BRK  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic step_q, run_q, halt_q;
    logic step_e, run_e, halt_e;
    logic halt_pend;
    logic done_ok;

    logic [ADDR_W-1:0] slot_addr [NUM_BKPT];
    logic [NUM_BKPT-1:0] slot_arm;
    logic bk_match;
    logic [IDX_W-1:0] bk_idx;

    assign step_e  = step_req & ~step_q;
    assign run_e   = run_req & ~run_q;
    assign halt_e  = halt_req & ~halt_q;
    assign done_ok = instr_done & cpu_run;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q <= 1'b0;
            run_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            step_q <= step_req;
            run_q  <= run_req;
            halt_q <= halt_req;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot_arm <= '0;
            for (int i = 0; i < NUM_BKPT; i++) begin
                slot_addr[i] <= '0;
            end
        end else if (bkpt_wr_en && (32'(bkpt_wr_idx) < NUM_BKPT)) begin
            slot_addr[bkpt_wr_idx] <= bkpt_wr_addr;
            slot_arm[bkpt_wr_idx]  <= bkpt_wr_valid;
        end
    end

    // Scan downward so the lowest matching slot is the one left standing.
    always_comb begin
        bk_match = 1'b0;
        bk_idx   = '0;
        for (int i = NUM_BKPT - 1; i >= 0; i--) begin
            if (slot_arm[i] && (slot_addr[i] == pc)) begin
                bk_match = 1'b1;
                bk_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, BRK: begin
                if (!slp) begin
                    if (step_e) begin
                        state_nx = STEP;
                    end else if (run_e) begin
                        state_nx = RUN;
                    end
                end
            end
            STEP: begin
                if (done_ok) begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (done_ok) begin
                    if (bk_match) begin
                        state_nx = BRK;
                    end else if (halt_pend || slp) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu_run  = (state == STEP) || (state == RUN);
        halted   = (state == IDLE) || (state == BRK);
        bkpt_hit = (state == BRK);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            halt_pend <= 1'b0;
        end else if (state == RUN && state_nx != RUN) begin
            halt_pend <= 1'b0;
        end else if (state == RUN && halt_e) begin
            halt_pend <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bkpt_hit_idx <= '0;
        end else if (state == RUN && state_nx == BRK) begin
            bkpt_hit_idx <= bk_idx;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_count <= '0;
        end else if (done_ok) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

`ifdef XM23_EXEC_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cyc_q <= '0;
        end else if (cpu_run) begin
            cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_xm23_exec_ctrl.sv
// Directed bench for xm23_exec_ctrl (4-bit counters to reach wrap quickly).
module tb_xm23_exec_ctrl;

    localparam bit CCEN =
`ifdef XM23_EXEC_CYCLE_CNT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        step_req, run_req, halt_req;
    logic        bkpt_wr_en, bkpt_wr_valid;
    logic [1:0]  bkpt_wr_idx;
    logic [15:0] bkpt_wr_addr, pc;
    logic        instr_done, slp;
    logic        cpu_run, halted, bkpt_hit;
    logic [1:0]  bkpt_hit_idx;
    logic [3:0]  instr_count, cycle_count;

    int checks = 0;
    int failures = 0;

    xm23_exec_ctrl #(.ADDR_W(16), .NUM_BKPT(4), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .step_req(step_req), .run_req(run_req), .halt_req(halt_req),
        .bkpt_wr_en(bkpt_wr_en), .bkpt_wr_idx(bkpt_wr_idx),
        .bkpt_wr_addr(bkpt_wr_addr), .bkpt_wr_valid(bkpt_wr_valid),
        .pc(pc), .instr_done(instr_done), .slp(slp),
        .cpu_run(cpu_run), .halted(halted), .bkpt_hit(bkpt_hit),
        .bkpt_hit_idx(bkpt_hit_idx), .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic st, rn, ht, dn, sl;
        logic [15:0] pc;
        logic we;
        logic [1:0] wi;
        logic [15:0] wa;
        logic wv;
        logic e_run, e_hlt, e_hit;
        logic [1:0] e_idx;
        logic [3:0] e_ic, e_cc;
    } vec_t;

    vec_t tv [21];

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic r, input logic h, input logic b);
        chk({nm, ".cpu_run"}, 32'(cpu_run), 32'(r));
        chk({nm, ".halted"}, 32'(halted), 32'(h));
        chk({nm, ".bkpt_hit"}, 32'(bkpt_hit), 32'(b));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic one_step(input logic [15:0] p);
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        instr_done = 1'b1;
        pc = p;
        cyc();
        instr_done = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        step_req = 0; run_req = 0; halt_req = 0;
        bkpt_wr_en = 0; bkpt_wr_idx = 0; bkpt_wr_addr = 0; bkpt_wr_valid = 0;
        pc = 0; instr_done = 0; slp = 0;

        //            st rn ht dn sl pc       we wi wa       wv  run hl hit idx ic  cc
        tv[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 1};
        tv[2]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 2};
        tv[3]  = '{1, 0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 1, 3};
        tv[4]  = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 1, 3};
        tv[5]  = '{0, 0, 0, 0, 0, 16'h0000, 1, 2, 16'h00F6, 1, 0, 1, 0, 0, 1, 3};
        tv[6]  = '{0, 1, 0, 0, 0, 16'h00F2, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 3};
        tv[7]  = '{0, 1, 0, 1, 0, 16'h00F2, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 2, 4};
        tv[8]  = '{0, 1, 0, 1, 0, 16'h00F4, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 3, 5};
        tv[9]  = '{0, 1, 0, 1, 0, 16'h00F6, 0, 0, 16'h0000, 0, 0, 1, 1, 2, 4, 6};
        tv[10] = '{0, 0, 0, 0, 0, 16'h00F6, 0, 0, 16'h0000, 0, 0, 1, 1, 2, 4, 6};
        tv[11] = '{0, 1, 0, 0, 0, 16'h00F6, 0, 0, 16'h0000, 0, 1, 0, 0, 2, 4, 6};
        tv[12] = '{0, 1, 0, 1, 0, 16'h00F8, 0, 0, 16'h0000, 0, 1, 0, 0, 2, 5, 7};
        tv[13] = '{0, 0, 0, 0, 0, 16'h00FA, 1, 1, 16'h0100, 1, 1, 0, 0, 2, 5, 8};
        tv[14] = '{0, 0, 0, 0, 0, 16'h00FA, 1, 3, 16'h0100, 1, 1, 0, 0, 2, 5, 9};
        tv[15] = '{0, 0, 0, 1, 0, 16'h0100, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 6, 10};
        tv[16] = '{0, 0, 0, 0, 0, 16'h0100, 1, 1, 16'h0100, 0, 0, 1, 1, 1, 6, 10};
        tv[17] = '{0, 1, 0, 0, 0, 16'h0100, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 6, 10};
        tv[18] = '{0, 0, 0, 1, 0, 16'h0100, 0, 0, 16'h0000, 0, 0, 1, 1, 3, 7, 11};
        tv[19] = '{0, 1, 0, 0, 0, 16'h0100, 0, 0, 16'h0000, 0, 1, 0, 0, 3, 7, 11};
        tv[20] = '{0, 1, 0, 1, 0, 16'h0102, 0, 0, 16'h0000, 0, 1, 0, 0, 3, 8, 12};

        do_reset();
        chk_state("rst", 1'b0, 1'b1, 1'b0);
        chk("rst.idx", 32'(bkpt_hit_idx), 32'd0);
        chk("rst.icnt", 32'(instr_count), 32'd0);
        chk("rst.ccnt", 32'(cycle_count), 32'd0);

        for (int i = 0; i < 21; i++) begin
            step_req = tv[i].st; run_req = tv[i].rn; halt_req = tv[i].ht;
            instr_done = tv[i].dn; slp = tv[i].sl; pc = tv[i].pc;
            bkpt_wr_en = tv[i].we; bkpt_wr_idx = tv[i].wi;
            bkpt_wr_addr = tv[i].wa; bkpt_wr_valid = tv[i].wv;
            cyc();
            chk_state($sformatf("vec%0d", i), tv[i].e_run, tv[i].e_hlt, tv[i].e_hit);
            chk($sformatf("vec%0d.idx", i), 32'(bkpt_hit_idx), 32'(tv[i].e_idx));
            chk($sformatf("vec%0d.icnt", i), 32'(instr_count), 32'(tv[i].e_ic));
            chk($sformatf("vec%0d.ccnt", i), 32'(cycle_count),
                CCEN ? 32'(tv[i].e_cc) : 32'd0);
        end
        instr_done = 0; bkpt_wr_en = 0;

        // halt edge five cycles ahead of the next retirement
        run_req = 0; halt_req = 1;
        cyc();
        chk("halt.c0", 32'(cpu_run), 32'd1);
        halt_req = 0;
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk($sformatf("halt.c%0d", k), 32'(cpu_run), 32'd1);
        end
        instr_done = 1; pc = 16'h0200;
        cyc();
        instr_done = 0;
        chk_state("halt.stop", 1'b0, 1'b1, 1'b0);
        chk("halt.icnt", 32'(instr_count), 32'd9);

        // halt edge outside RUN must not stop a later run
        halt_req = 1;
        cyc();
        halt_req = 0; run_req = 1;
        cyc();
        instr_done = 1; pc = 16'h0300;
        cyc();
        instr_done = 0;
        chk_state("halt_idle.run", 1'b1, 1'b0, 1'b0);
        chk("halt_idle.icnt", 32'(instr_count), 32'd10);

        // sleep stops RUN and blocks requests
        slp = 1; instr_done = 1; pc = 16'h0302;
        cyc();
        instr_done = 0;
        chk_state("slp.stop", 1'b0, 1'b1, 1'b0);
        chk("slp.icnt", 32'(instr_count), 32'd11);
        run_req = 0;
        cyc();
        run_req = 1;
        cyc();
        chk_state("slp.run_blk", 1'b0, 1'b1, 1'b0);
        step_req = 1;
        cyc();
        chk_state("slp.step_blk", 1'b0, 1'b1, 1'b0);
        step_req = 0; run_req = 0; slp = 0;
        instr_done = 1;
        cyc();
        instr_done = 0;
        chk("idle_done_ignored", 32'(instr_count), 32'd11);

        // counter wrap at 4 bits
        do_reset();
        for (int k = 0; k < 15; k++) one_step(16'h0010);
        chk("wrap.icnt15", 32'(instr_count), 32'd15);
        chk("wrap.ccnt15", 32'(cycle_count), CCEN ? 32'd15 : 32'd0);
        one_step(16'h0010);
        chk("wrap.icnt0", 32'(instr_count), 32'd0);
        chk("wrap.ccnt0", 32'(cycle_count), 32'd0);
        chk_state("wrap.idle", 1'b0, 1'b1, 1'b0);

        // breakpoints are not checked in STEP
        bkpt_wr_en = 1; bkpt_wr_idx = 0; bkpt_wr_addr = 16'h0040; bkpt_wr_valid = 1;
        cyc();
        bkpt_wr_en = 0;
        one_step(16'h0040);
        chk_state("step_nobk", 1'b0, 1'b1, 1'b0);
        chk("step_nobk.icnt", 32'(instr_count), 32'd1);

        // reset in RUN clears state, counters and slots
        run_req = 1;
        cyc();
        instr_done = 1; pc = 16'h0042;
        cyc();
        instr_done = 0;
        chk("prerst.icnt", 32'(instr_count), 32'd2);
        Reset = 1; step_req = 1; instr_done = 1;
        cyc();
        Reset = 0; step_req = 0; instr_done = 0; run_req = 0;
        chk_state("rst_run", 1'b0, 1'b1, 1'b0);
        chk("rst_run.icnt", 32'(instr_count), 32'd0);
        chk("rst_run.ccnt", 32'(cycle_count), 32'd0);
        cyc();
        run_req = 1;
        cyc();
        instr_done = 1; pc = 16'h0040;
        cyc();
        instr_done = 0;
        chk_state("rst_slot_clear", 1'b1, 1'b0, 1'b0);
        chk("rst_slot_clear.icnt", 32'(instr_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
